// File: rtl/sram_port_pkg.sv
// sram_port_pkg: shared response-entry type and pipeline constants for the sram1rw port controller.
package sram_port_pkg;
    localparam int RSP_LATENCY    = 2;
    localparam int RSP_DATA_WIDTH = 32;
    typedef struct packed {
        logic                      is_wr;
        logic [RSP_DATA_WIDTH-1:0] rdata;
    } rsp_entry_t;
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: flop-based FIFO; pointers wrap modulo DEPTH so any DEPTH >= 2 works.
module sram_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 33
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [OW-1:0]    occ_q, occ_d;
    logic             do_pop;
    assign full   = occ_q == OW'(DEPTH);
    assign empty  = occ_q == '0;
    assign occ    = occ_q;
    assign rdata  = mem_q[rptr_q];
    assign do_pop = pop && !empty;
    assign occ_d  = occ_q + OW'(push) - OW'(do_pop);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q == LAST ? '0 : wptr_q + 1'b1;
            if (do_pop) rptr_q <= rptr_q == LAST ? '0 : rptr_q + 1'b1;
            occ_q <= occ_d;
        end
    end
    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/sram1rw_port_ctrl.sv
// sram1rw_port_ctrl: valid/ready front-end for one sram1rw with a credit-managed response FIFO.
// Define SRAM_PORT_CTRL_WR_ACK_EN to return an in-order ack (rsp_is_wr = 1) for every write.
module sram1rw_port_ctrl
    import sram_port_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = RSP_DATA_WIDTH,
    parameter int RSP_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_is_wr,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);
`ifdef SRAM_PORT_CTRL_WR_ACK_EN
    localparam logic WR_ACK = 1'b1;
`else
    localparam logic WR_ACK = 1'b0;
`endif
    localparam int OW = $clog2(RSP_DEPTH + 1);
    logic          fire, pop, full, empty;
    logic          inflight_q, inflight_d, wr_q, wr_d;
    logic [OW-1:0] occ;
    rsp_entry_t    push_e, head_e;
    // Credits count queued plus in-flight responses, so the FIFO can never overflow.
    assign req_ready  = !rst && (int'(occ) + int'(inflight_q) < RSP_DEPTH);
    assign fire       = req_valid && req_ready;
    assign sram_we    = fire && req_we;
    assign sram_addr  = req_addr;
    assign sram_wdata = req_wdata;
    assign inflight_d = fire && (WR_ACK || !req_we);
    assign wr_d       = fire && req_we && WR_ACK;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            wr_q       <= wr_d;
        end
    end
    // sram_rdata is only valid for this one cycle, so capture it straight into the FIFO.
    assign push_e.is_wr = wr_q;
    assign push_e.rdata = wr_q ? '0 : sram_rdata;
    sram_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH($bits(rsp_entry_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .wdata (push_e),
        .pop   (pop),
        .rdata (head_e),
        .full  (full),
        .empty (empty),
        .occ   (occ)
    );
    assign rsp_valid = !empty;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_rdata = rsp_valid ? head_e.rdata : '0;
    assign rsp_is_wr = WR_ACK && rsp_valid && head_e.is_wr;
    push_full_a: assert property (@(posedge clk) disable iff (rst) !(inflight_q && full));
endmodule

// File: tb/tb_sram1rw_port_ctrl.sv
// tb_sram1rw_port_ctrl: directed and randomized check of sram1rw_port_ctrl against a request-level model.
module tb_sram1rw_port_ctrl;
    import sram_port_pkg::*;
`ifdef SRAM_PORT_CTRL_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic req_ready, rsp_valid, rsp_is_wr, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] rsp_rdata, sram_wdata, sram_rdata;
    logic [DW-1:0] mem [256];
    int n_tests = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    sram1rw_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_is_wr  (rsp_is_wr),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );
    // Attached sram1rw: 1-cycle synchronous read, rdata refreshed every cycle, never reset.
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
        sram_rdata <= mem[sram_addr];
    end
    // Request-level model: a list of owed responses, each becoming visible RSP_LATENCY cycles after accept.
    typedef struct {
        logic          is_wr;
        logic [DW-1:0] d;
        int            t;
    } exp_t;
    exp_t exp_q[$];
    logic [DW-1:0] ref_mem [256];
    int cyc = 0;
    function automatic logic m_ready();
        return !rst && exp_q.size() < DEPTH;
    endfunction
    function automatic logic m_valid();
        return !rst && exp_q.size() > 0 && cyc >= exp_q[0].t + RSP_LATENCY;
    endfunction
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            bit f, p;
            exp_t e;
            f = req_valid && m_ready();
            p = m_valid() && rsp_ready;
            if (p) void'(exp_q.pop_front());
            if (f && req_we) ref_mem[req_addr] = req_wdata;
            if (f && (WR_ACK || !req_we)) begin
                e.is_wr = req_we;
                e.d = req_we ? '0 : ref_mem[req_addr];
                e.t = cyc;
                exp_q.push_back(e);
            end
            cyc++;
        end
    end
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask
    always @(negedge clk) begin
        chk("req_ready", req_ready, m_ready());
        chk("rsp_valid", rsp_valid, m_valid());
        chk("sram_we", sram_we, req_valid && m_ready() && req_we);
        chk("sram_addr", sram_addr, req_addr);
        if (m_valid()) begin
            chk("rsp_rdata", rsp_rdata, exp_q[0].d);
            chk("rsp_is_wr", rsp_is_wr, exp_q[0].is_wr);
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic we, input int a, input logic [DW-1:0] d);
        req_valid = v;
        req_we = we;
        req_addr = AW'(a);
        req_wdata = d;
    endtask
    initial begin
        int acc;
        #2;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_is_wr", rsp_is_wr, 0);
        step;
        step;
        rst = 1'b0;
        rsp_ready = 1'b1;
        // Write then read-after-write to 0x10.
        drive(1, 1, 'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk("ready_first_cycle", req_ready, 1);
        step;
        drive(1, 0, 'h10, 0);
        @(negedge clk);
        chk("raw_rd_ready", req_ready, 1);
        step;
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("raw_n1_valid", rsp_valid, WR_ACK);
        step;
        @(negedge clk);
        chk("raw_n2_valid", rsp_valid, 1);
        chk("raw_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("raw_is_wr", rsp_is_wr, 0);
        step;
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, i, DW'(i * 3));
            step;
        end
        drive(0, 0, 0, 0);
        repeat (4) step;
        // Back-to-back reads, one response per cycle.
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive(1, 0, i, 0);
            else drive(0, 0, 0, 0);
            @(negedge clk);
            if (i < 16) chk("b2b_ready", req_ready, 1);
            if (i >= 2) begin
                chk("b2b_valid", rsp_valid, 1);
                chk("b2b_rdata", rsp_rdata, DW'((i - 2) * 3));
            end
            step;
        end
        // Backpressure: only RSP_DEPTH reads are taken.
        drive(0, 0, 0, 0);
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (acc < 5) drive(1, 0, acc, 0);
            else drive(0, 0, 0, 0);
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            step;
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("stall_accepts", DW'(acc), 3);
        chk("stall_ready", req_ready, 0);
        chk("stall_head", rsp_rdata, 0);
        step;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("drain_valid", rsp_valid, 1);
            chk("drain_rdata", rsp_rdata, DW'(k * 3));
            step;
        end
        @(negedge clk);
        chk("drain_ready", req_ready, 1);
        chk("drain_empty", rsp_valid, 0);
        step;
        // Reset with one read in flight and two queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, i, 0);
            step;
        end
        drive(0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_rdata", rsp_rdata, 0);
        step;
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step;
            @(negedge clk);
            chk("no_stale", rsp_valid, 0);
        end
        step;
        drive(1, 0, 1, 0);
        step;
        drive(0, 0, 0, 0);
        step;
        @(negedge clk);
        chk("retained_valid", rsp_valid, 1);
        chk("retained_rdata", rsp_rdata, 3);
        step;
        // Random traffic with alternating light and heavy backpressure.
        for (int i = 0; i < 10000; i++) begin
            req_valid = ($urandom % 3) != 0;
            req_we = ($urandom % 3) == 0;
            req_addr = AW'($urandom % 16);
            req_wdata = $urandom;
            rsp_ready = ((i / 500) % 2) != 0 ? ($urandom % 8) == 0 : ($urandom % 4) != 0;
            step;
        end
        drive(0, 0, 0, 0);
        rsp_ready = 1'b1;
        repeat (8) step;
        @(negedge clk);
        chk("final_empty", rsp_valid, 0);
        chk("final_ready", req_ready, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
